// File: rtl/uart_txer.sv
// UART transmitter: 8N1 framing with a one-byte holding register so that
// consecutive frames can be sent with no idle gap between stop and start bits.
module uart_txer #(
  parameter int unsigned BIT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       res,
  input  logic [7:0] data_in,
  input  logic       en_data_in,
  output logic       TX,
  output logic       busy,
  output logic       rdy
);

  localparam logic [12:0] LastCnt = 13'(BIT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e      state_q, state_d;
  logic [12:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic        tx_q, tx_d;
  logic        accept;
  logic        bit_end;

  assign accept  = en_data_in & ~hold_full_q;
  assign bit_end = (cnt_q == LastCnt);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    tx_d        = tx_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          shift_d = data_in;
          cnt_d   = 13'd0;
          tx_d    = 1'b0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          cnt_d   = 13'd0;
          idx_d   = 3'd0;
          tx_d    = shift_q[0];
          state_d = StData;
        end else begin
          cnt_d = cnt_q + 13'd1;
        end
      end
      StData: begin
        if (bit_end) begin
          cnt_d = 13'd0;
          if (idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = StStop;
          end else begin
            idx_d   = idx_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + 13'd1;
        end
      end
      StStop: begin
        if (bit_end) begin
          cnt_d = 13'd0;
          if (hold_full_q) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            tx_d        = 1'b0;
            state_d     = StStart;
          end else if (en_data_in) begin
            shift_d = data_in;
            tx_d    = 1'b0;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + 13'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Mid-frame writes park in the holding register; the final stop cycle
    // instead hands the byte straight to the shifter above.
    if (accept && (state_q != StIdle) && !((state_q == StStop) && bit_end)) begin
      hold_d      = data_in;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q     <= StIdle;
      cnt_q       <= 13'd0;
      idx_q       <= 3'd0;
      shift_q     <= 8'd0;
      hold_q      <= 8'd0;
      hold_full_q <= 1'b0;
      tx_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx_q        <= tx_d;
    end
  end

  assign TX   = tx_q;
  assign busy = (state_q != StIdle);
  assign rdy  = ~hold_full_q;

endmodule
